// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Drives the ALU operands and op select one cycle after the ID inputs are captured.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic [2:0]      id_alu_sel_i,
  input  logic            id_alu_src_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_branch_i,
  input  logic            exmem_reg_write_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_alu_out_i,
  input  logic            memwb_reg_write_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] alu_inp1_o,
  output logic [XLEN-1:0] alu_inp2_o,
  output logic [2:0]      alu_sel_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_branch_o,
  output logic            ex_valid_o,
  output logic            load_use_stall_o
);

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      alu_sel;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            valid;
  } ex_t;

  ex_t ex_d, ex_q;

  logic            lus;
  logic            exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // A load in EX cannot forward its data until it reaches MEM/WB, so the consumer waits a cycle.
  always_comb begin
    lus = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid_i &
          ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));
  end

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (stall_i) begin
      ex_d = ex_q;
    end else if (lus) begin
      ex_d = '0;
    end else begin
      ex_d.rs1_data  = id_rs1_data_i;
      ex_d.rs2_data  = id_rs2_data_i;
      ex_d.imm       = id_imm_i;
      ex_d.rs1       = id_rs1_i;
      ex_d.rs2       = id_rs2_i;
      ex_d.rd        = id_rd_i;
      ex_d.alu_sel   = id_alu_sel_i;
      ex_d.alu_src   = id_alu_src_i;
      ex_d.reg_write = id_reg_write_i & id_valid_i;
      ex_d.mem_read  = id_mem_read_i & id_valid_i;
      ex_d.mem_write = id_mem_write_i & id_valid_i;
      ex_d.branch    = id_branch_i & id_valid_i;
      ex_d.valid     = id_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Index 0 is hardwired zero and must never pick up a forwarded value.
  always_comb begin
    exmem_hit1 = exmem_reg_write_i & (exmem_rd_i != '0) & (exmem_rd_i == ex_q.rs1);
    exmem_hit2 = exmem_reg_write_i & (exmem_rd_i != '0) & (exmem_rd_i == ex_q.rs2);
    memwb_hit1 = memwb_reg_write_i & (memwb_rd_i != '0) & (memwb_rd_i == ex_q.rs1);
    memwb_hit2 = memwb_reg_write_i & (memwb_rd_i != '0) & (memwb_rd_i == ex_q.rs2);

    if (exmem_hit1) begin
      fwd_rs1 = exmem_alu_out_i;
    end else if (memwb_hit1) begin
      fwd_rs1 = memwb_result_i;
    end else begin
      fwd_rs1 = ex_q.rs1_data;
    end

    if (exmem_hit2) begin
      fwd_rs2 = exmem_alu_out_i;
    end else if (memwb_hit2) begin
      fwd_rs2 = memwb_result_i;
    end else begin
      fwd_rs2 = ex_q.rs2_data;
    end
  end

  always_comb begin
    alu_inp1_o       = fwd_rs1;
    alu_inp2_o       = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    alu_sel_o        = ex_q.alu_sel;
    ex_store_data_o  = fwd_rs2;
    ex_rd_o          = ex_q.rd;
    ex_reg_write_o   = ex_q.reg_write;
    ex_mem_read_o    = ex_q.mem_read;
    ex_mem_write_o   = ex_q.mem_write;
    ex_branch_o      = ex_q.branch;
    ex_valid_o       = ex_q.valid;
    load_use_stall_o = lus;
  end

endmodule
